counter_ctrl: RTL and testbench

- Sequencer for the 8-bit preset/reset/enable counter used on the Vbuddy lab board.
- Turns raw button/flag inputs (start, stop, step, load, clear) and a programmable rate into one-cycle command pulses: cnt_en, cnt_rst and cnt_pst.
- Detects the terminal count and then either wraps the counter or halts it.
- Sits between the Vbuddy I/O wrapper and the counter instance; the counter's count output feeds back into this block.

---
 rtl/counter_ctrl_pkg.sv | 40 ++++
 rtl/edge_detect.sv | 29 ++
 rtl/counter_ctrl.sv | 169 ++++++++++++++++
 tb/tb_counter_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the Vbuddy counter sequencer: FSM states, decoded
// commands and the button priority order.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RUN,
        PAUSED,
        LOAD,
        DONE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_STEP,
        CMD_START,
        CMD_STOP,
        CMD_LOAD,
        CMD_CLR
    } cmd_t;

    // Bit positions in the button vector; higher index wins.
    localparam int N_BTN     = 5;
    localparam int BTN_STEP  = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_LOAD  = 3;
    localparam int BTN_CLR   = 4;

    function automatic cmd_t select_cmd(input logic [N_BTN-1:0] rise);
        if (rise[BTN_CLR])        return CMD_CLR;
        else if (rise[BTN_LOAD])  return CMD_LOAD;
        else if (rise[BTN_STOP])  return CMD_STOP;
        else if (rise[BTN_START]) return CMD_START;
        else if (rise[BTN_STEP])  return CMD_STEP;
        else                      return CMD_NONE;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchroniser for one button with a registered one-cycle
// rising-edge output.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_q1;
    logic r_q2;
    logic r_rise;

    // NOTE: non-blocking assignments so q2 takes the old q1, forming a real shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1   <= 1'b0;
            r_q2   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_q1   <= i_btn;
            r_q2   <= r_q1;
            r_rise <= r_q1 & ~r_q2;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for the Vbuddy preset/reset/enable counter: turns button edges
// and a prescaled rate into one-cycle cnt_en / cnt_rst / cnt_pst commands.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 step,
    input  logic                 load,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [WIDTH-1:0]     limit,
    input  logic                 auto_wrap,
    input  logic [WIDTH-1:0]     count,
    output logic                 cnt_en,
    output logic                 cnt_rst,
    output logic                 cnt_pst,
    output logic                 running,
    output logic                 done
);

    logic [N_BTN-1:0]     w_btn;
    logic [N_BTN-1:0]     w_rise;
    cmd_t                 w_cmd;

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [DIV_WIDTH-1:0] r_presc;
    logic [DIV_WIDTH-1:0] w_presc_next;

    logic                 r_cnt_en;
    logic                 r_cnt_rst;
    logic                 r_cnt_pst;
    logic                 r_running;
    logic                 r_done;
    logic                 w_en_next;
    logic                 w_rst_next;
    logic                 w_pst_next;

    logic [WIDTH-1:0]     w_eff;
    logic                 w_at_limit;
    logic                 w_tick;

    assign w_btn[BTN_STEP]  = step;
    assign w_btn[BTN_START] = start;
    assign w_btn[BTN_STOP]  = stop;
    assign w_btn[BTN_LOAD]  = load;
    assign w_btn[BTN_CLR]   = clr;

    for (genvar g = 0; g < N_BTN; g++) begin : g_edge
        edge_detect u_edge (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_btn[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_cmd = select_cmd(w_rise);

    // Value the counter will hold after this edge: a pending clear reads as 0,
    // a pending increment as count + 1, so back-to-back ticks never overshoot.
    assign w_eff      = r_cnt_rst ? '0 : count + {{(WIDTH-1){1'b0}}, r_cnt_en};
    assign w_at_limit = (w_eff == limit);
    assign w_tick     = (r_presc == div);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_en_next    = 1'b0;
        w_rst_next   = 1'b0;
        w_pst_next   = 1'b0;

        if (w_cmd == CMD_CLR) begin
            w_state_next = CLEAR;
            w_rst_next   = 1'b1;
        end else if (w_cmd == CMD_LOAD &&
                     (r_state == IDLE || r_state == RUN ||
                      r_state == PAUSED || r_state == DONE)) begin
            w_state_next = LOAD;
            w_pst_next   = 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    // Entry via clr already issued the pulse; entry via reset did not.
                    w_rst_next   = ~r_cnt_rst;
                    w_state_next = IDLE;
                end
                IDLE: begin
                    if (w_cmd == CMD_START) begin
                        w_state_next = RUN;
                    end else if (w_cmd == CMD_STEP) begin
                        w_en_next    = 1'b1;
                        w_state_next = PAUSED;
                    end
                end
                RUN: begin
                    if (w_cmd == CMD_STOP) begin
                        w_state_next = PAUSED;
                    end else if (w_tick) begin
                        w_presc_next = '0;
                        if (!w_at_limit)   w_en_next    = 1'b1;
                        else if (auto_wrap) w_rst_next   = 1'b1;
                        else               w_state_next = DONE;
                    end else begin
                        w_presc_next = r_presc + DIV_WIDTH'(1);
                    end
                end
                PAUSED: begin
                    if (w_cmd == CMD_START) begin
                        w_state_next = RUN;
                    end else if (w_cmd == CMD_STEP) begin
                        if (!w_at_limit)    w_en_next  = 1'b1;
                        else if (auto_wrap) w_rst_next = 1'b1;
                    end
                end
                LOAD: begin
                    w_state_next = PAUSED;
                end
                DONE: begin
                    if (w_cmd == CMD_START) begin
                        w_rst_next   = 1'b1;
                        w_state_next = RUN;
                    end
                end
                default: begin
                    w_state_next = CLEAR;
                end
            endcase
        end

        if (w_state_next == RUN && r_state != RUN) begin
            w_presc_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_presc   <= '0;
            r_cnt_en  <= 1'b0;
            r_cnt_rst <= 1'b0;
            r_cnt_pst <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_cnt_en  <= w_en_next;
            r_cnt_rst <= w_rst_next;
            r_cnt_pst <= w_pst_next;
            r_running <= (w_state_next == RUN);
            r_done    <= (w_state_next == DONE);
        end
    end

    assign cnt_en  = r_cnt_en;
    assign cnt_rst = r_cnt_rst;
    assign cnt_pst = r_cnt_pst;
    assign running = r_running;
    assign done    = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench: counter_ctrl driving a behavioural preset/reset/enable
// counter, with hand-computed expectations for each scenario.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [15:0] div;
    logic [7:0]  limit;
    logic        auto_wrap;
    logic [7:0]  count;
    logic [7:0]  vbuddy;
    logic        cnt_en, cnt_rst, cnt_pst, running, done;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (btn[BTN_START]),
        .stop      (btn[BTN_STOP]),
        .step      (btn[BTN_STEP]),
        .load      (btn[BTN_LOAD]),
        .clr       (btn[BTN_CLR]),
        .div       (div),
        .limit     (limit),
        .auto_wrap (auto_wrap),
        .count     (count),
        .cnt_en    (cnt_en),
        .cnt_rst   (cnt_rst),
        .cnt_pst   (cnt_pst),
        .running   (running),
        .done      (done)
    );

    // Vbuddy counter: clear beats preset beats increment.
    always_ff @(posedge clk) begin
        if (rst)          count <= 8'd0;
        else if (cnt_rst) count <= 8'd0;
        else if (cnt_pst) count <= vbuddy;
        else if (cnt_en)  count <= count + 8'd1;
    end

    // Pulse/transition log sampled on the falling edge.
    int         cyc_n    = 0;
    int         n_en     = 0;
    int         n_rst    = 0;
    int         n_pst    = 0;
    int         n_excl   = 0;
    int         done_cyc = 0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_cnt  = 8'd0;
    int         en_q[$];
    logic [7:0] chg_q[$];

    always @(negedge clk) begin
        cyc_n++;
        if (cnt_en)  begin n_en++; en_q.push_back(cyc_n); end
        if (cnt_rst) n_rst++;
        if (cnt_pst) n_pst++;
        if (int'(cnt_en) + int'(cnt_rst) + int'(cnt_pst) > 1) n_excl++;
        if (done && !prev_done) done_cyc = cyc_n;
        if (count !== prev_cnt) chg_q.push_back(count);
        prev_done = done;
        prev_cnt  = count;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold a button pattern for two samples, then release and let it settle.
    task automatic press(input logic [4:0] mask);
        btn = mask;
        cyc(2);
        btn = 5'b0;
    endtask

    int base_en, base_rst, base_pst, base_q, base_c;
    logic [7:0] c0;
    logic [7:0] cmax;

    initial begin
        rst       = 1'b1;
        btn       = 5'b0;
        div       = 16'd0;
        limit     = 8'd0;
        auto_wrap = 1'b0;
        vbuddy    = 8'h00;

        // 1: reset, then idle
        cyc(3);
        check("rst_outputs", {27'd0, cnt_en, cnt_rst, cnt_pst, running, done}, 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(CLEAR));
        base_rst = n_rst;
        base_en  = n_en;
        rst = 1'b0;
        cyc(1);
        check("clear_pulse", {31'd0, cnt_rst}, 32'd1);
        cyc(20);
        check("clear_once", n_rst - base_rst, 1);
        check("idle_no_en", n_en - base_en, 0);
        check("idle_count", count, 0);
        check("idle_state", 32'(dut.r_state), 32'(IDLE));

        // 2: div=3, limit=5, halt at limit
        div = 16'd3; limit = 8'd5; auto_wrap = 1'b0;
        base_q = en_q.size();
        base_c = chg_q.size();
        press(5'b1 << BTN_START);
        cyc(40);
        check("t2_en_pulses", en_q.size() - base_q, 5);
        if (en_q.size() - base_q == 5) begin
            for (int i = 0; i < 4; i++)
                check("t2_en_spacing", en_q[base_q+i+1] - en_q[base_q+i], 4);
            check("t2_done_latency", done_cyc - en_q[base_q+4], 4);
        end
        check("t2_changes", chg_q.size() - base_c, 5);
        if (chg_q.size() - base_c == 5)
            for (int i = 0; i < 5; i++)
                check("t2_seq", chg_q[base_c+i], i + 1);
        check("t2_done", {31'd0, done}, 1);
        check("t2_running", {31'd0, running}, 0);
        check("t2_hold", count, 5);

        // 3: full-rate wrap at limit=2 (start from DONE issues a clear first)
        div = 16'd0; limit = 8'd2; auto_wrap = 1'b1;
        base_c = chg_q.size();
        press(5'b1 << BTN_START);
        cyc(20);
        check("t3_running", {31'd0, running}, 1);
        if (chg_q.size() - base_c >= 7) begin
            for (int i = 0; i < 7; i++)
                check("t3_seq", chg_q[base_c+i], (i % 3));
        end else begin
            check("t3_changes", chg_q.size() - base_c, 7);
        end
        cmax = 8'd0;
        for (int i = base_c; i < chg_q.size(); i++)
            if (chg_q[i] > cmax) cmax = chg_q[i];
        check("t3_max", cmax, 2);

        // 4: stop, three steps, resume
        div = 16'd2; limit = 8'd200;
        cyc(6);
        btn = 5'b1 << BTN_STOP;
        cyc(2);
        check("t4_run_still", {31'd0, running}, 1);
        btn = 5'b0;
        cyc(1);
        check("t4_run_fall", {31'd0, running}, 0);
        check("t4_paused", 32'(dut.r_state), 32'(PAUSED));
        cyc(5);
        c0 = count;
        base_en = n_en;
        for (int i = 0; i < 3; i++) begin
            press(5'b1 << BTN_STEP);
            cyc(3);
        end
        check("t4_steps_en", n_en - base_en, 3);
        check("t4_steps_cnt", count, c0 + 8'd3);
        base_en = n_en;
        btn = 5'b1 << BTN_START;
        cyc(2);
        btn = 5'b0;
        cyc(12);
        check("t4_resume_en", n_en - base_en, 3);
        check("t4_resume_cnt", count, c0 + 8'd6);
        check("t4_resume_run", {31'd0, running}, 1);

        // 5: load 0x42 while running
        vbuddy   = 8'h42;
        base_pst = n_pst;
        press(5'b1 << BTN_LOAD);
        cyc(8);
        check("t5_pst_once", n_pst - base_pst, 1);
        check("t5_count", count, 32'h42);
        check("t5_state", 32'(dut.r_state), 32'(PAUSED));
        check("t5_running", {31'd0, running}, 0);

        // 6: reach DONE at 0x44, then clr and start together
        div = 16'd0; limit = 8'h44; auto_wrap = 1'b0;
        press(5'b1 << BTN_START);
        cyc(8);
        check("t6_done", {31'd0, done}, 1);
        check("t6_count", count, 32'h44);
        base_rst = n_rst;
        base_en  = n_en;
        press((5'b1 << BTN_CLR) | (5'b1 << BTN_START));
        cyc(10);
        check("t6_rst_once", n_rst - base_rst, 1);
        check("t6_no_en", n_en - base_en, 0);
        check("t6_count0", count, 0);
        check("t6_state", 32'(dut.r_state), 32'(IDLE));
        check("t6_flags", {30'd0, running, done}, 0);

        // 7: limit=0, halt: first tick goes straight to DONE
        limit   = 8'd0;
        base_en = n_en;
        press(5'b1 << BTN_START);
        cyc(8);
        check("t7_done", {31'd0, done}, 1);
        check("t7_no_en", n_en - base_en, 0);
        check("t7_count", count, 0);

        // 8: reset mid-run
        limit = 8'd200;
        press(5'b1 << BTN_START);
        cyc(6);
        check("t8_running", {31'd0, running}, 1);
        rst = 1'b1;
        cyc(1);
        check("t8_rst_outputs", {27'd0, cnt_en, cnt_rst, cnt_pst, running, done}, 0);
        check("t8_rst_state", 32'(dut.r_state), 32'(CLEAR));
        base_rst = n_rst;
        rst = 1'b0;
        cyc(6);
        check("t8_clear_once", n_rst - base_rst, 1);
        check("t8_state", 32'(dut.r_state), 32'(IDLE));
        check("t8_count", count, 0);

        check("exclusive_pulses", n_excl, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
